fetch_stage: RTL and testbench



---
 rtl/fetch_if.sv | 11 +
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Requests are single-cycle pulses; responses return in order, one per request.
interface fetch_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemValid;
  logic [31:0] imemRdata;

  modport master (output imemReq, imemAddr, input imemValid, imemRdata);
  modport slave  (input imemReq, imemAddr, output imemValid, imemRdata);
endinterface

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: one outstanding imem read, a one-entry hold
// buffer to absorb ID stalls, redirect from EX and bubble insertion on flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     imem,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        stallD,
  input  logic        flushD,
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        validD
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FULL, S_KILL} state_t;

  state_t      r_state;
  logic [31:0] r_pcf;
  logic [31:0] r_req_pc;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;

  state_t      w_state_nxt;
  logic        w_stall;
  logic        w_resp;
  logic        w_issue;
  logic        w_deliver;
  logic        w_capture;
  logic [31:0] w_word;
  logic [31:0] w_dpc;

  // A flush overrides the stall, so a response arriving under flush is
  // consumed (and lost to the bubble) rather than parked in the buffer.
  assign w_stall = stallD & ~flushD;
  assign w_resp  = (r_state == S_WAIT) & imem.imemValid;

  always_comb begin
    w_deliver   = 1'b0;
    w_capture   = 1'b0;
    w_issue     = 1'b0;
    w_state_nxt = r_state;
    w_word      = imem.imemRdata;
    w_dpc       = r_req_pc;
    case (r_state)
      S_IDLE: begin
        if (!PCSrcE) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imemValid) begin
          if (PCSrcE) begin
            w_state_nxt = S_IDLE;
          end else if (w_stall) begin
            w_capture   = 1'b1;
            w_state_nxt = S_FULL;
          end else begin
            w_deliver   = 1'b1;
            w_issue     = 1'b1;
          end
        end else if (PCSrcE) begin
          w_state_nxt = S_KILL;
        end
      end
      S_FULL: begin
        w_word = r_hold_instr;
        w_dpc  = r_hold_pc;
        if (PCSrcE) begin
          w_state_nxt = S_IDLE;
        end else if (!w_stall) begin
          w_deliver   = 1'b1;
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      default: begin
        if (imem.imemValid) begin
          w_issue     = ~PCSrcE;
          w_state_nxt = PCSrcE ? S_IDLE : S_WAIT;
        end
      end
    endcase
  end

  assign imem.imemReq  = w_issue & ~rst;
  assign imem.imemAddr = r_pcf;

  // Fetch control and PC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pcf   <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (PCSrcE)
        r_pcf <= PCTargetE & ~32'h3;
      else if (w_issue)
        r_pcf <= r_pcf + 32'd4;
    end
  end

  // Request PC and hold buffer payload; occupancy is tracked by r_state
  always_ff @(posedge clk) begin
    if (w_issue)
      r_req_pc <= r_pcf;
    if (w_capture) begin
      r_hold_instr <= imem.imemRdata;
      r_hold_pc    <= r_req_pc;
    end
  end

  // IF/ID register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrD   <= NOP_INSTR;
      PCD      <= 32'h0;
      PCPlus4D <= 32'h0;
      validD   <= 1'b0;
    end else if (flushD) begin
      instrD <= NOP_INSTR;
      validD <= 1'b0;
    end else if (!stallD) begin
      if (w_deliver) begin
        instrD   <= w_word;
        PCD      <= w_dpc;
        PCPlus4D <= w_dpc + 32'd4;
        validD   <= 1'b1;
      end else begin
        instrD <= NOP_INSTR;
        validD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable memory, a
// transaction-level model of the fetch rules, and literal checkpoints.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        stallD = 1'b0;
  logic        flushD = 1'b0;
  logic [31:0] instrD, PCD, PCPlus4D;
  logic        validD;

  fetch_if bus();

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .imem(bus),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .stallD(stallD), .flushD(flushD),
    .instrD(instrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .validD(validD)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat = 1;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] req_log[$];

  // model: fetch bookkeeping plus the ID-visible values
  logic [31:0] m_pc, m_rpc, m_bword, m_bpc;
  logic        m_busy, m_doomed, m_hbuf;
  logic [31:0] m_instr, m_pcd, m_pc4;
  logic        m_vld;
  logic        exp_req;
  logic [31:0] exp_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd7) + 32'h0000_1003;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_busy = 1'b0; m_doomed = 1'b0; m_hbuf = 1'b0;
    m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0; m_vld = 1'b0;
  endtask

  task automatic model_eval(input logic s, input logic f, input logic p,
                            input logic [31:0] t, input logic v, input logic [31:0] rd);
    logic es, resp, dlv;
    logic [31:0] dword, dpc;
    es = s & ~f;
    resp = v & m_busy;
    dlv = 1'b0; dword = 32'h0; dpc = 32'h0;
    exp_req = 1'b0; exp_addr = 32'h0;
    if (p) begin
      if (m_busy) begin
        if (resp) begin m_busy = 1'b0; m_doomed = 1'b0; end
        else m_doomed = 1'b1;
      end
      m_hbuf = 1'b0;
      m_pc = t & ~32'h3;
    end else begin
      if (resp) begin
        m_busy = 1'b0;
        if (m_doomed) m_doomed = 1'b0;
        else if (es) begin m_hbuf = 1'b1; m_bword = rd; m_bpc = m_rpc; end
        else begin dlv = 1'b1; dword = rd; dpc = m_rpc; end
      end else if (m_hbuf && !es) begin
        dlv = 1'b1; dword = m_bword; dpc = m_bpc; m_hbuf = 1'b0;
      end
      if (!m_busy && !m_hbuf) begin
        exp_req = 1'b1; exp_addr = m_pc; m_rpc = m_pc; m_pc = m_pc + 32'd4; m_busy = 1'b1;
      end
    end
    if (f) begin
      m_instr = NOP; m_vld = 1'b0;
    end else if (!s) begin
      if (dlv) begin
        m_instr = dword; m_pcd = dpc; m_pc4 = dpc + 32'd4; m_vld = 1'b1;
      end else begin
        m_instr = NOP; m_vld = 1'b0;
      end
    end
  endtask

  task automatic cmp_id(input string tag);
    chk({"instrD", tag}, instrD, m_instr);
    chk({"PCD", tag}, PCD, m_pcd);
    chk({"PCPlus4D", tag}, PCPlus4D, m_pc4);
    chk({"validD", tag}, {31'b0, validD}, {31'b0, m_vld});
  endtask

  // One clock: drive inputs and memory response, compare, advance.
  task automatic step(input logic r, input logic s, input logic f,
                      input logic p, input logic [31:0] t);
    @(negedge clk);
    rst = r; stallD = s; flushD = f; PCSrcE = p; PCTargetE = t;
    bus.imemValid = 1'b0;
    bus.imemRdata = $urandom;
    for (int i = 0; i < pend_due.size(); i++) begin
      if (pend_due[i] == cyc) begin
        bus.imemValid = 1'b1;
        bus.imemRdata = mem_word(pend_addr[i]);
        pend_due.delete(i);
        pend_addr.delete(i);
        break;
      end
    end
    #1;
    if (r) model_reset();
    cmp_id("_pre");
    if (r) begin
      exp_req = 1'b0; exp_addr = 32'h0;
    end else begin
      model_eval(s, f, p, t, bus.imemValid, bus.imemRdata);
    end
    chk("imemReq", {31'b0, bus.imemReq}, {31'b0, exp_req});
    if (exp_req) chk("imemAddr", bus.imemAddr, exp_addr);
    if (bus.imemReq) begin
      req_log.push_back(bus.imemAddr);
      pend_addr.push_back(bus.imemAddr);
      pend_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cmp_id("_post");
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  int vcount;
  int n0;

  initial begin
    bus.imemValid = 1'b0;
    bus.imemRdata = 32'h0;
    rst = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_instrD", instrD, 32'h0000_0013);
    chk("rst_PCD", PCD, 32'h0);
    chk("rst_PCPlus4D", PCPlus4D, 32'h0);
    chk("rst_validD", {31'b0, validD}, 32'h0);
    chk("rst_imemReq", {31'b0, bus.imemReq}, 32'h0);

    // latency 1 streaming
    lat = 1;
    req_log.delete();
    run(2);
    chk("s1_PCD0", PCD, 32'h0);
    chk("s1_PC4_0", PCPlus4D, 32'h4);
    chk("s1_instr0", instrD, mem_word(32'h0));
    chk("s1_valid", {31'b0, validD}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("s1_PCD4", PCD, 32'h4);
    chk("s1_PC4_4", PCPlus4D, 32'h8);
    chk("s1_addr0", req_log[0], 32'h0);
    chk("s1_addr1", req_log[1], 32'h4);
    chk("s1_addr2", req_log[2], 32'h8);

    // latency 3: one fetch per three cycles
    lat = 3;
    run(3);
    n0 = req_log.size();
    vcount = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      if (validD) vcount++;
    end
    chk("s2_deliveries", vcount, 3);
    chk("s2_requests", req_log.size() - n0, 3);

    // stall while the response for 0x10 arrives
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    lat = 1;
    req_log.delete();
    run(5);
    n0 = req_log.size();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("s3_hold_PCD", PCD, 32'hC);
    chk("s3_hold_valid", {31'b0, validD}, 32'h1);
    chk("s3_no_req", req_log.size(), n0);
    lat = 3;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("s3_rel_PCD", PCD, 32'h10);
    chk("s3_rel_instr", instrD, mem_word(32'h10));
    chk("s3_next_addr", req_log[req_log.size()-1], 32'h14);

    // redirect while waiting, late response dropped
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
    run(2);
    chk("s4_target_addr", req_log[req_log.size()-1], 32'h100);
    run(3);
    chk("s4_PCD", PCD, 32'h100);
    chk("s4_valid", {31'b0, validD}, 32'h1);

    // redirect coincident with response, flush and stall
    run(2);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    chk("s5_instr_nop", instrD, 32'h0000_0013);
    chk("s5_valid", {31'b0, validD}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("s5_target_addr", req_log[req_log.size()-1], 32'h200);

    // PC wrap at the top of the address space
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    run(1);
    lat = 1;
    run(1);
    chk("s6_top_addr", req_log[req_log.size()-1], 32'hFFFF_FFFC);
    run(1);
    chk("s6_PCD", PCD, 32'hFFFF_FFFC);
    chk("s6_PCPlus4D", PCPlus4D, 32'h0);
    chk("s6_wrap_addr", req_log[req_log.size()-1], 32'h0);

    // reset while a request is outstanding; its response lands in IDLE
    lat = 2;
    run(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("s7_rst_instr", instrD, 32'h0000_0013);
    chk("s7_rst_valid", {31'b0, validD}, 32'h0);
    req_log.delete();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("s7_first_addr", req_log[0], RESET_PC);
    run(2);
    chk("s7_PCD", PCD, RESET_PC);
    chk("s7_instr", instrD, mem_word(RESET_PC));
    chk("s7_valid", {31'b0, validD}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
